// File: rtl/echo_sample_accum.sv
// Echo window accumulator: syncs gated acq/add/entop strobes, sums win_len ADC samples per window.
// Strobes act 3 clk_sys after their rising edge; 1-deep output register, results dropped (ovf_err) when full.
module echo_sample_accum #(
    parameter int DW      = 12,
    parameter int SW      = 24,
    parameter int NW      = 12,
    parameter int OFS_BIN = 1
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] win_len,
    input  logic          clk_acq,
    input  logic          clk_add,
    input  logic          entop,
    input  logic [DW-1:0] adc_data,
    output logic [SW-1:0] sum_data,
    output logic          sum_valid,
    input  logic          sum_ready,
    output logic [NW-1:0] echo_idx,
    output logic          busy,
    output logic          done,
    output logic          ovf_err
);

    typedef enum logic [1:0] {IDLE, ARM, ACCUM, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    acq_sr, add_sr, ent_sr;
    logic          acq_stb, add_stb, entop_fall;
    logic [DW-1:0] adc_tc;
    logic [SW-1:0] sample_ext;
    logic [SW-1:0] acc, acc_nxt, res_q;
    logic [NW-1:0] cnt, cnt_nxt, win_eff;
    logic          res_pend;
    logic          start_ok;

    // Two flops resolve metastability, the third gives the edge reference.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acq_sr <= '0;
            add_sr <= '0;
            ent_sr <= '0;
        end else begin
            acq_sr <= {acq_sr[1:0], clk_acq};
            add_sr <= {add_sr[1:0], clk_add};
            ent_sr <= {ent_sr[1:0], entop};
        end
    end

    assign acq_stb    = acq_sr[1] & ~acq_sr[2];
    assign add_stb    = add_sr[1] & ~add_sr[2];
    assign entop_fall = ~ent_sr[1] & ent_sr[2];

    assign adc_tc     = {adc_data[DW-1] ^ (OFS_BIN != 0), adc_data[DW-2:0]};
    assign sample_ext = {{(SW-DW){adc_tc[DW-1]}}, adc_tc};
    assign acc_nxt    = acc + sample_ext;
    assign cnt_nxt    = cnt + NW'(1);
    assign start_ok   = start & ((state == IDLE) | (state == DONE));

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     if (entop_fall) state_nxt = DONE;
                     else if (add_stb) state_nxt = ACCUM;
            ACCUM:   if (entop_fall) state_nxt = DONE;
            DONE:    if (start) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ARM) | (state == ACCUM);
        done = (state == DONE);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            win_eff   <= NW'(1);
            acc       <= '0;
            cnt       <= '0;
            res_q     <= '0;
            res_pend  <= 1'b0;
            echo_idx  <= '0;
            sum_data  <= '0;
            sum_valid <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            res_pend <= 1'b0;
            if (start_ok) begin
                win_eff  <= (win_len == '0) ? NW'(1) : win_len;
                acc      <= '0;
                cnt      <= '0;
                echo_idx <= '0;
                ovf_err  <= 1'b0;
            end else if (state == ACCUM && acq_stb) begin
                if (cnt_nxt == win_eff) begin
                    res_q    <= acc_nxt;
                    res_pend <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                    echo_idx <= echo_idx + NW'(1);
                end else begin
                    acc <= acc_nxt;
                    cnt <= cnt_nxt;
                end
            end
            // A result arriving while the consumer is stalled is lost rather than stalling capture.
            if (res_pend) begin
                if (sum_valid && !sum_ready) begin
                    ovf_err <= 1'b1;
                end else begin
                    sum_data  <= res_q;
                    sum_valid <= 1'b1;
                end
            end else if (sum_valid && sum_ready) begin
                sum_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_echo_sample_accum.sv
// Directed bench for echo_sample_accum; expected window sums queued at stimulus, popped by a monitor.
module tb_echo_sample_accum;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] win_len;
    logic        clk_acq;
    logic        clk_add;
    logic        entop;
    logic [11:0] adc_data;
    logic [23:0] sum_data;
    logic        sum_valid;
    logic        sum_ready;
    logic [11:0] echo_idx;
    logic        busy;
    logic        done;
    logic        ovf_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] exp_q[$];

    echo_sample_accum #(.DW(12), .SW(24), .NW(12), .OFS_BIN(1)) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .start     (start),
        .win_len   (win_len),
        .clk_acq   (clk_acq),
        .clk_add   (clk_add),
        .entop     (entop),
        .adc_data  (adc_data),
        .sum_data  (sum_data),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .echo_idx  (echo_idx),
        .busy      (busy),
        .done      (done),
        .ovf_err   (ovf_err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic acq(input logic [11:0] d);
        adc_data = d;
        clk_acq  = 1'b1;
        cyc(3);
        clk_acq  = 1'b0;
        cyc(4);
    endtask

    task automatic addp();
        clk_add = 1'b1;
        cyc(3);
        clk_add = 1'b0;
        cyc(4);
    endtask

    task automatic do_start(input logic [11:0] wl);
        win_len = wl;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
        cyc(1);
    endtask

    // Monitor samples just after the falling edge, once stimulus for the next rising edge has settled.
    always begin
        @(negedge clk_sys);
        #1;
        if (rst_n && sum_valid && sum_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sum_unexpected: got %h expected none", sum_data);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                if (sum_data !== e) begin
                    miscompares++;
                    $display("FAIL sum_data: got %h expected %h", sum_data, e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; win_len = '0; clk_acq = 1'b0; clk_add = 1'b0;
        entop = 1'b0; adc_data = '0; sum_ready = 1'b1;
        cyc(2);
        chk("rst_sum_data", 32'(sum_data), 32'h0);
        chk("rst_sum_valid", 32'(sum_valid), 32'h0);
        chk("rst_echo_idx", 32'(echo_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovf_err", 32'(ovf_err), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // T1: basic window of 4, start while busy must be ignored
        entop = 1'b1;
        do_start(12'd4);
        chk("t1_busy_arm", 32'(busy), 32'h1);
        addp();
        do_start(12'd1);
        exp_q.push_back(24'd10);
        acq(12'h801); acq(12'h802); acq(12'h803); acq(12'h804);
        cyc(3);
        chk("t1_echo_idx", 32'(echo_idx), 32'h1);
        chk("t1_busy", 32'(busy), 32'h1);
        entop = 1'b0;
        cyc(6);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_busy_end", 32'(busy), 32'h0);

        // T2: acquisitions before the first clk_add are dead time
        entop = 1'b1;
        do_start(12'd4);
        chk("t2_done_clr", 32'(done), 32'h0);
        acq(12'h9FF); acq(12'h123); acq(12'hC00);
        addp();
        exp_q.push_back(24'hFFFFFC);
        repeat (4) acq(12'h7FF);
        cyc(3);
        chk("t2_echo_idx", 32'(echo_idx), 32'h1);
        entop = 1'b0;
        cyc(6);

        // T3: consumer stalled across two windows
        entop = 1'b1;
        sum_ready = 1'b0;
        do_start(12'd4);
        addp();
        exp_q.push_back(24'd20);
        repeat (4) acq(12'h805);
        repeat (4) acq(12'h801);
        cyc(3);
        chk("t3_ovf_err", 32'(ovf_err), 32'h1);
        chk("t3_echo_idx", 32'(echo_idx), 32'h2);
        chk("t3_valid_held", 32'(sum_valid), 32'h1);
        chk("t3_data_held", 32'(sum_data), 32'd20);
        sum_ready = 1'b1;
        cyc(3);
        chk("t3_valid_drop", 32'(sum_valid), 32'h0);

        // T4: scan ends mid-window; partial sum discarded
        acq(12'h801); acq(12'h801);
        entop = 1'b0;
        cyc(8);
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_echo_idx", 32'(echo_idx), 32'h2);
        chk("t4_no_result", 32'(sum_valid), 32'h0);

        // T5: win_len 0 behaves as 1
        entop = 1'b1;
        do_start(12'd0);
        chk("t5_ovf_clr", 32'(ovf_err), 32'h0);
        addp();
        exp_q.push_back(24'd0);        acq(12'h800);
        exp_q.push_back(24'hFFFFF0);   acq(12'h7F0);
        exp_q.push_back(24'd16);       acq(12'h810);
        cyc(3);
        chk("t5_echo_idx", 32'(echo_idx), 32'h3);
        chk("t5_ovf_err", 32'(ovf_err), 32'h0);
        entop = 1'b0;
        cyc(6);

        // T6: reset mid-accumulation, then a clean scan
        entop = 1'b1;
        do_start(12'd4);
        addp();
        acq(12'h801); acq(12'h801);
        rst_n = 1'b0;
        #1;
        chk("t6_sum_data", 32'(sum_data), 32'h0);
        chk("t6_sum_valid", 32'(sum_valid), 32'h0);
        chk("t6_echo_idx", 32'(echo_idx), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_done", 32'(done), 32'h0);
        chk("t6_ovf_err", 32'(ovf_err), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        do_start(12'd2);
        addp();
        exp_q.push_back(24'd8);
        acq(12'h803); acq(12'h805);
        cyc(3);
        chk("t6_echo_idx_new", 32'(echo_idx), 32'h1);
        entop = 1'b0;
        cyc(8);
        chk("t6_done_new", 32'(done), 32'h1);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
